mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage directly downstream of the main execute stage.
- Accepts one execute result per handshake and waits for the dcache response on loads and stores.
- Aligns and extends load data by byte, halfword or word.
- Presents a registered writeback record to the WB stage, with pause/flush interplay toward ctrl.

Parameters:
- ADDR_W, 32, address / PC width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept this cycle
- in_pc  in  32  instruction PC
- in_aluop  in  8  aluop, codes from core_defines (`ALU_LDB/LDBU/LDH/LDHU/LDW/LLW/STB/STH/STW/SCW)
- in_mem_addr  in  32  effective address from execute
- in_mem_req  in  1  execute issued a dcache request (valid or uncache_en) for this instruction
- in_is_exception  in  1  OR of exception bits from upstream
- in_reg_write_en  in  1  GPR write enable
- in_reg_write_addr  in  5  GPR index
- in_reg_write_data  in  32  non-load result
- dcache_data_ok  in  1  dcache response pulse
- dcache_rdata  in  32  dcache read word
- flush  in  1  pipeline flush from ctrl
- wb_allow  in  1  WB stage accepts this cycle
- out_valid  out  1  writeback record valid
- out_pc  out  32  PC
- out_reg_write_en  out  1  GPR write enable (forced 0 if in_is_exception)
- out_reg_write_addr  out  5  GPR index
- out_reg_write_data  out  32  final write data
- pause_mem  out  1  stall request to ctrl
- fwd_valid  out  1  load-data bypass valid (optional feature)
- fwd_addr  out  5  bypass GPR index
- fwd_data  out  32  bypass data

Behaviour:
- Reset: state IDLE, drop_pending=0, all outputs 0 (in_ready=0 while rst is asserted).
- States:
  - IDLE: no outstanding request.
  - WAIT: request outstanding; captured fields held in internal registers.
- in_ready = (state==IDLE) && (!out_valid || wb_allow) && !drop_pending.
- Accept = in_valid && in_ready && !flush.
- Accept with in_mem_req=0 or in_is_exception=1: output register loaded next edge; out_valid=1; latency 1.
- Accept with in_mem_req=1 and no exception: go to WAIT.
- WAIT:
  - On dcache_data_ok: compute write data, load output register, out_valid=1, return to IDLE.
  - data_ok in the accept cycle is not counted.
- Load extraction, off = mem_addr[1:0]:
  - LDB: sign-extended byte rdata[8*off+7:8*off]; LDBU: same byte, zero-extended.
  - LDH: sign-extended half rdata[16*off[1]+15:16*off[1]]; LDHU: same half, zero-extended.
  - LDW/LLW: rdata.
- Stores and SCW: write data = captured in_reg_write_data (SCW carries LLbit).
- out_valid clears on wb_allow unless a new record loads in the same cycle.
- Output record is held unchanged while wb_allow=0.
- pause_mem = (state==WAIT && !dcache_data_ok) || drop_pending.
- Flush:
  - Clears out_valid next edge; state to IDLE.
  - Flush in WAIT without same-cycle data_ok: set drop_pending.
  - Flush with same-cycle data_ok: response consumed, drop_pending stays 0.
  - drop_pending clears on the next data_ok; that data is discarded.
  - flush while drop_pending: drop_pending stays 1 (still one response owed).
- Asynchronous rst mid-WAIT: everything returns to reset values; no response bookkeeping kept.
- in_valid with in_ready=0: upstream holds its inputs; not consumed.

Optional Feature:
- MEM_LOAD_FWD_EN defined:
  - fwd_valid = state==WAIT && dcache_data_ok && !drop_pending && captured reg_write_en && captured load op, combinational.
  - fwd_addr/fwd_data carry the aligned load value in the same cycle, one cycle before out_valid.
- Undefined: fwd_valid, fwd_addr and fwd_data tied 0.

Test Plan:
- ADD result 0x12345678 to r5, wb_allow=1 -> next cycle out_valid=1, r5, 0x12345678; pause_mem never 1.
- LDB at addr 0x...3, data_ok after 3 cycles with rdata 0x80AABBCC:
  - pause_mem high for 3 cycles.
  - Then out_reg_write_data=0xFFFFFF80; LDBU gives 0x00000080.
- LDH at addr 0x...2 with rdata 0x8001_7FFF -> 0xFFFF8001; LDHU -> 0x00008001.
- Load accepted, flush 1 cycle later, data_ok 2 cycles after flush:
  - out_valid stays 0; in_ready=0 until that data_ok.
  - Next load then completes normally.
- Flush and data_ok in the same WAIT cycle -> no drop_pending; following instruction accepted next cycle.
- Load completes while wb_allow=0 for 2 cycles -> output held stable, in_ready=0; released on wb_allow.
- With MEM_LOAD_FWD_EN: fwd_valid asserts in the data_ok cycle with the correct data.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and data bundle for mem_stage: execute input, dcache response,
// ctrl flush/pause, writeback record and optional load bypass.
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [7:0]        in_aluop;
    logic [ADDR_W-1:0] in_mem_addr;
    logic              in_mem_req;
    logic              in_is_exception;
    logic              in_reg_write_en;
    logic [4:0]        in_reg_write_addr;
    logic [DATA_W-1:0] in_reg_write_data;
    logic              dcache_data_ok;
    logic [DATA_W-1:0] dcache_rdata;
    logic              flush;
    logic              wb_allow;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic              out_reg_write_en;
    logic [4:0]        out_reg_write_addr;
    logic [DATA_W-1:0] out_reg_write_data;
    logic              pause_mem;
    logic              fwd_valid;
    logic [4:0]        fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    modport slave (
        input  in_valid, in_pc, in_aluop, in_mem_addr, in_mem_req, in_is_exception,
               in_reg_write_en, in_reg_write_addr, in_reg_write_data,
               dcache_data_ok, dcache_rdata, flush, wb_allow,
        output in_ready, out_valid, out_pc, out_reg_write_en, out_reg_write_addr,
               out_reg_write_data, pause_mem, fwd_valid, fwd_addr, fwd_data
    );

    modport master (
        output in_valid, in_pc, in_aluop, in_mem_addr, in_mem_req, in_is_exception,
               in_reg_write_en, in_reg_write_addr, in_reg_write_data,
               dcache_data_ok, dcache_rdata, flush, wb_allow,
        input  in_ready, out_valid, out_pc, out_reg_write_en, out_reg_write_addr,
               out_reg_write_data, pause_mem, fwd_valid, fwd_addr, fwd_data
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: waits for dcache responses, aligns/extends load data, drives WB record.
// Optional combinational load bypass enabled by defining MEM_LOAD_FWD_EN.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       rst,
    mem_stage_if.slave bus
);
    localparam logic [7:0] ALU_LDB  = 8'h20;
    localparam logic [7:0] ALU_LDBU = 8'h21;
    localparam logic [7:0] ALU_LDH  = 8'h22;
    localparam logic [7:0] ALU_LDHU = 8'h23;
    localparam logic [7:0] ALU_LDW  = 8'h24;
    localparam logic [7:0] ALU_LLW  = 8'h25;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic              drop_q, drop_d;
    logic [7:0]        aluop_q, aluop_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_we_q, out_we_d;
    logic [4:0]        out_waddr_q, out_waddr_d;
    logic [DATA_W-1:0] out_wdata_q, out_wdata_d;

    logic              in_ready;
    logic              accept;
    logic              wait_done;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.in_mem_addr[ADDR_W-1:2];

    assign in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || bus.wb_allow) && !drop_q;
    assign accept    = bus.in_valid && in_ready && !bus.flush;
    assign wait_done = (state_q == WAIT) && bus.dcache_data_ok;

    // Non-load ops (stores, SCW) fall through to the captured write data.
    always_comb begin
        ld_byte = bus.dcache_rdata[{off_q, 3'b000} +: 8];
        ld_half = bus.dcache_rdata[{off_q[1], 4'b0000} +: 16];
        case (aluop_q)
            ALU_LDB:          ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            ALU_LDBU:         ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            ALU_LDH:          ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            ALU_LDHU:         ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            ALU_LDW, ALU_LLW: ld_data = bus.dcache_rdata;
            default:          ld_data = wdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        aluop_d     = aluop_q;
        off_d       = off_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_we_d    = out_we_q;
        out_waddr_d = out_waddr_q;
        out_wdata_d = out_wdata_q;

        if (accept) begin
            aluop_d = bus.in_aluop;
            off_d   = bus.in_mem_addr[1:0];
            we_d    = bus.in_reg_write_en;
            waddr_d = bus.in_reg_write_addr;
            wdata_d = bus.in_reg_write_data;
            pc_d    = bus.in_pc;
        end

        case (state_q)
            IDLE: begin
                if (drop_q && bus.dcache_data_ok)
                    drop_d = 1'b0;
                if (accept && bus.in_mem_req && !bus.in_is_exception)
                    state_d = WAIT;
            end
            WAIT: begin
                // A flush racing the response consumes it; otherwise one response is still owed.
                if (bus.flush) begin
                    state_d = IDLE;
                    if (!bus.dcache_data_ok)
                        drop_d = 1'b1;
                end else if (bus.dcache_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept && (!bus.in_mem_req || bus.in_is_exception)) begin
            out_valid_d = 1'b1;
            out_pc_d    = bus.in_pc;
            out_we_d    = bus.in_reg_write_en && !bus.in_is_exception;
            out_waddr_d = bus.in_reg_write_addr;
            out_wdata_d = bus.in_reg_write_data;
        end else if (wait_done) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_we_d    = we_q;
            out_waddr_d = waddr_q;
            out_wdata_d = ld_data;
        end else if (bus.wb_allow) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            aluop_q     <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_we_q    <= 1'b0;
            out_waddr_q <= '0;
            out_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            aluop_q     <= aluop_d;
            off_q       <= off_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_we_q    <= out_we_d;
            out_waddr_q <= out_waddr_d;
            out_wdata_q <= out_wdata_d;
        end
    end

    assign bus.in_ready           = in_ready;
    assign bus.out_valid          = out_valid_q;
    assign bus.out_pc             = out_pc_q;
    assign bus.out_reg_write_en   = out_we_q;
    assign bus.out_reg_write_addr = out_waddr_q;
    assign bus.out_reg_write_data = out_wdata_q;
    assign bus.pause_mem          = ((state_q == WAIT) && !bus.dcache_data_ok) || drop_q;

`ifdef MEM_LOAD_FWD_EN
    logic is_load_q;
    logic fwd_valid;
    assign is_load_q     = aluop_q inside {ALU_LDB, ALU_LDBU, ALU_LDH, ALU_LDHU, ALU_LDW, ALU_LLW};
    assign fwd_valid     = wait_done && !drop_q && we_q && is_load_q;
    assign bus.fwd_valid = fwd_valid;
    assign bus.fwd_addr  = fwd_valid ? waddr_q : '0;
    assign bus.fwd_data  = fwd_valid ? ld_data : '0;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_addr  = '0;
    assign bus.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized ALU/load/store traffic against a
// byte-shift reference model, plus flush, drop, back-pressure and reset scenarios.
module tb_mem_stage;
    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_LDB  = 8'h20;
    localparam logic [7:0] ALU_LDBU = 8'h21;
    localparam logic [7:0] ALU_LDH  = 8'h22;
    localparam logic [7:0] ALU_LDHU = 8'h23;
    localparam logic [7:0] ALU_LDW  = 8'h24;
    localparam logic [7:0] ALU_LLW  = 8'h25;
    localparam logic [7:0] ALU_STB  = 8'h26;
    localparam logic [7:0] ALU_STH  = 8'h27;
    localparam logic [7:0] ALU_STW  = 8'h28;
    localparam logic [7:0] ALU_SCW  = 8'h29;

    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic is_load(input logic [7:0] op);
        return (op >= ALU_LDB) && (op <= ALU_LLW);
    endfunction

    // Reference: shift the word right by the byte lane, mask, then sign-fix by subtraction.
    function automatic logic [31:0] ref_data(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd, input logic [31:0] st);
        int unsigned lane = addr % 4;
        logic [31:0] b = (rd >> (lane * 8)) & 32'hFF;
        logic [31:0] h = (rd >> ((lane / 2) * 16)) & 32'hFFFF;
        case (op)
            ALU_LDB:          return (b >= 32'd128)   ? b - 32'd256     : b;
            ALU_LDBU:         return b;
            ALU_LDH:          return (h >= 32'h8000)  ? h - 32'h10000   : h;
            ALU_LDHU:         return h;
            ALU_LDW, ALU_LLW: return rd;
            default:          return st;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic req,
                         input logic exc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pc);
        bus.in_valid          = 1'b1;
        bus.in_aluop          = op;
        bus.in_mem_addr       = addr;
        bus.in_mem_req        = req;
        bus.in_is_exception   = exc;
        bus.in_reg_write_en   = we;
        bus.in_reg_write_addr = wa;
        bus.in_reg_write_data = wd;
        bus.in_pc             = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(ALU_ADD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 32'h100);
        bus.wb_allow = 1'b1;
        tick();
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", bus.out_valid); end
        total++; if (bus.pause_mem !== 1'b0) begin bad++; $display("FAIL rst_pause got=%0h exp=0", bus.pause_mem); end
        total++; if (bus.out_reg_write_data !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.out_reg_write_data); end
        total++; if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL rst_fwd got=%0h exp=0", bus.fwd_valid); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_after_valid got=%0h exp=0", bus.out_valid); end
    endtask

    task automatic test_alu();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] pc = $urandom;
            logic [31:0] d  = (i == 0) ? 32'h12345678 : $urandom;
            logic [4:0]  a  = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
            logic exc = (i != 0) && ($urandom_range(0, 2) == 0);
            logic we  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            logic req = exc ? 1'($urandom_range(0, 1)) : 1'b0;
            logic [7:0] op = req ? ALU_LDW : ALU_ADD;
            bus.wb_allow = 1'b1;
            drive(op, $urandom, req, exc, we, a, d, pc);
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL alu_ready i=%0d got=%0h exp=1", i, bus.in_ready); end
            tick();
            bus.in_valid = 1'b0;
            #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL alu_valid i=%0d got=%0h exp=1", i, bus.out_valid); end
            total++; if (bus.out_pc !== pc) begin bad++; $display("FAIL alu_pc i=%0d got=%h exp=%h", i, bus.out_pc, pc); end
            total++; if (bus.out_reg_write_en !== (we && !exc)) begin bad++; $display("FAIL alu_we i=%0d got=%0h exp=%0h", i, bus.out_reg_write_en, we && !exc); end
            total++; if (bus.out_reg_write_addr !== a) begin bad++; $display("FAIL alu_waddr i=%0d got=%0d exp=%0d", i, bus.out_reg_write_addr, a); end
            total++; if (bus.out_reg_write_data !== d) begin bad++; $display("FAIL alu_wdata i=%0d got=%h exp=%h", i, bus.out_reg_write_data, d); end
            total++; if (bus.pause_mem !== 1'b0) begin bad++; $display("FAIL alu_pause i=%0d got=%0h exp=0", i, bus.pause_mem); end
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL alu_drain i=%0d got=%0h exp=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_loads();
        logic [7:0] ops [10] = '{ALU_LDB, ALU_LDBU, ALU_LDH, ALU_LDHU, ALU_LDW,
                                 ALU_LLW, ALU_STB, ALU_STH, ALU_STW, ALU_SCW};
        for (int i = 0; i < 28; i++) begin
            logic [7:0]  op;
            logic [31:0] addr, rd, exp;
            logic [31:0] st = $urandom;
            logic [31:0] pc = $urandom;
            logic [4:0]  wa = 5'($urandom_range(1, 31));
            logic        we;
            int          lat, pcnt, rcnt;
            if (i < 4) begin
                op   = ops[i];
                addr = (i < 2) ? 32'h0000_1003 : 32'h0000_2002;
                rd   = (i < 2) ? 32'h80AA_BBCC : 32'h8001_7FFF;
                lat  = 3;
                we   = 1'b1;
            end else begin
                op   = ops[$urandom_range(0, 9)];
                addr = $urandom;
                rd   = $urandom;
                lat  = $urandom_range(1, 4);
                we   = 1'($urandom_range(0, 1));
            end
            exp = ref_data(op, addr, rd, st);
            bus.wb_allow = 1'b1;
            drive(op, addr, 1'b1, 1'b0, we, wa, st, pc);
            // A response pulse in the accept cycle belongs to nobody and must be ignored.
            bus.dcache_data_ok = (i >= 4) && ($urandom_range(0, 1) == 1);
            bus.dcache_rdata   = ~rd;
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ld_ready i=%0d got=%0h exp=1", i, bus.in_ready); end
            tick();
            bus.in_valid       = 1'b0;
            bus.dcache_data_ok = 1'b0;
            pcnt = 0;
            rcnt = 0;
            for (int k = 0; k < lat; k++) begin
                #1;
                if (bus.pause_mem === 1'b1) pcnt++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) rcnt++;
                tick();
            end
            total++; if (pcnt != lat) begin bad++; $display("FAIL ld_pause_cycles i=%0d got=%0d exp=%0d", i, pcnt, lat); end
            total++; if (rcnt != 0) begin bad++; $display("FAIL ld_wait_idle i=%0d got=%0d exp=0", i, rcnt); end
            bus.dcache_data_ok = 1'b1;
            bus.dcache_rdata   = rd;
            #1;
            total++; if (bus.pause_mem !== 1'b0) begin bad++; $display("FAIL ld_pause_ok i=%0d got=%0h exp=0", i, bus.pause_mem); end
`ifdef MEM_LOAD_FWD_EN
            total++; if (bus.fwd_valid !== (we && is_load(op))) begin bad++; $display("FAIL fwd_valid i=%0d got=%0h exp=%0h", i, bus.fwd_valid, we && is_load(op)); end
            if (we && is_load(op)) begin
                total++; if (bus.fwd_data !== exp || bus.fwd_addr !== wa) begin bad++; $display("FAIL fwd_data i=%0d got=%h/%0d exp=%h/%0d", i, bus.fwd_data, bus.fwd_addr, exp, wa); end
            end
`else
            total++; if (bus.fwd_valid !== 1'b0 || bus.fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_tied i=%0d got=%0h/%h exp=0/0", i, bus.fwd_valid, bus.fwd_data); end
`endif
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ld_early i=%0d got=%0h exp=0", i, bus.out_valid); end
            tick();
            bus.dcache_data_ok = 1'b0;
            bus.dcache_rdata   = $urandom;
            #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ld_valid i=%0d got=%0h exp=1", i, bus.out_valid); end
            total++; if (bus.out_reg_write_data !== exp) begin bad++; $display("FAIL ld_data i=%0d op=%h addr=%h got=%h exp=%h", i, op, addr, bus.out_reg_write_data, exp); end
            total++; if (bus.out_reg_write_en !== we || bus.out_reg_write_addr !== wa || bus.out_pc !== pc) begin bad++; $display("FAIL ld_fields i=%0d got=%0h/%0d/%h exp=%0h/%0d/%h", i, bus.out_reg_write_en, bus.out_reg_write_addr, bus.out_pc, we, wa, pc); end
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ld_drain i=%0d got=%0h exp=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_flush_wait();
        logic [31:0] rd = $urandom;
        bus.wb_allow = 1'b1;
        drive(ALU_LDW, 32'h40, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h200);
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        // Second flush while the stale response is still owed.
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.pause_mem !== 1'b1) begin bad++; $display("FAIL fl_drop got=%0h/%0h/%0h exp=0/0/1", bus.out_valid, bus.in_ready, bus.pause_mem); end
        tick();
        bus.flush = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0 || bus.pause_mem !== 1'b1) begin bad++; $display("FAIL fl_drop_kept got=%0h/%0h exp=0/1", bus.in_ready, bus.pause_mem); end
        bus.dcache_data_ok = 1'b1;
        bus.dcache_rdata   = $urandom;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready_ok got=%0h exp=0", bus.in_ready); end
        tick();
        bus.dcache_data_ok = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pause_mem !== 1'b0) begin bad++; $display("FAIL fl_discard got=%0h/%0h/%0h exp=0/1/0", bus.out_valid, bus.in_ready, bus.pause_mem); end
        drive(ALU_LDBU, 32'h41, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 32'h204);
        tick();
        bus.in_valid       = 1'b0;
        bus.dcache_data_ok = 1'b1;
        bus.dcache_rdata   = rd;
        tick();
        bus.dcache_data_ok = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_reg_write_data !== ref_data(ALU_LDBU, 32'h41, rd, 32'h0)) begin bad++; $display("FAIL fl_next got=%0h/%h exp=1/%h", bus.out_valid, bus.out_reg_write_data, ref_data(ALU_LDBU, 32'h41, rd, 32'h0)); end
        tick();
    endtask

    task automatic test_flush_dataok();
        bus.wb_allow = 1'b0;
        drive(ALU_ADD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55AA55AA, 32'h300);
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fo_held got=%0h exp=1", bus.out_valid); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fo_flush_clr got=%0h exp=0", bus.out_valid); end
        bus.wb_allow = 1'b1;
        drive(ALU_LDW, 32'h80, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0, 32'h304);
        tick();
        bus.in_valid       = 1'b0;
        bus.flush          = 1'b1;
        bus.dcache_data_ok = 1'b1;
        bus.dcache_rdata   = 32'hCAFEF00D;
        tick();
        bus.flush          = 1'b0;
        bus.dcache_data_ok = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pause_mem !== 1'b0) begin bad++; $display("FAIL fo_nodrop got=%0h/%0h/%0h exp=0/1/0", bus.out_valid, bus.in_ready, bus.pause_mem); end
        drive(ALU_ADD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0BADC0DE, 32'h308);
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_reg_write_data !== 32'h0BADC0DE) begin bad++; $display("FAIL fo_next got=%0h/%h exp=1/0badc0de", bus.out_valid, bus.out_reg_write_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd  = $urandom;
        logic [31:0] exp = ref_data(ALU_LDH, 32'h102, rd, 32'h0);
        logic [31:0] d2  = $urandom;
        bus.wb_allow = 1'b1;
        drive(ALU_LDH, 32'h102, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0, 32'h400);
        tick();
        bus.in_valid       = 1'b0;
        bus.wb_allow       = 1'b0;
        bus.dcache_data_ok = 1'b1;
        bus.dcache_rdata   = rd;
        tick();
        bus.dcache_data_ok = 1'b0;
        drive(ALU_ADD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd13, d2, 32'h404);
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (bus.out_valid !== 1'b1 || bus.out_reg_write_data !== exp || bus.out_pc !== 32'h400) begin bad++; $display("FAIL bp_hold k=%0d got=%0h/%h/%h exp=1/%h/400", k, bus.out_valid, bus.out_reg_write_data, bus.out_pc, exp); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready k=%0d got=%0h exp=0", k, bus.in_ready); end
            tick();
        end
        bus.wb_allow = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0h exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_reg_write_data !== d2 || bus.out_pc !== 32'h404) begin bad++; $display("FAIL bp_next got=%0h/%h/%h exp=1/%h/404", bus.out_valid, bus.out_reg_write_data, bus.out_pc, d2); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0h exp=0", bus.out_valid); end
    endtask

    task automatic test_rst_mid_wait();
        bus.wb_allow = 1'b1;
        drive(ALU_LDW, 32'h500, 1'b1, 1'b0, 1'b1, 5'd14, 32'h0, 32'h500);
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.pause_mem !== 1'b1) begin bad++; $display("FAIL rw_waiting got=%0h exp=1", bus.pause_mem); end
        rst = 1'b1;
        #1;
        total++; if (bus.pause_mem !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rw_async got=%0h/%0h/%0h exp=0/0/0", bus.pause_mem, bus.in_ready, bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        bus.dcache_data_ok = 1'b1;
        bus.dcache_rdata   = 32'h12121212;
        tick();
        bus.dcache_data_ok = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pause_mem !== 1'b0) begin bad++; $display("FAIL rw_clean got=%0h/%0h/%0h exp=0/1/0", bus.out_valid, bus.in_ready, bus.pause_mem); end
    endtask

    initial begin
        rst                   = 1'b1;
        bus.in_valid          = 1'b0;
        bus.in_pc             = '0;
        bus.in_aluop          = '0;
        bus.in_mem_addr       = '0;
        bus.in_mem_req        = 1'b0;
        bus.in_is_exception   = 1'b0;
        bus.in_reg_write_en   = 1'b0;
        bus.in_reg_write_addr = '0;
        bus.in_reg_write_data = '0;
        bus.dcache_data_ok    = 1'b0;
        bus.dcache_rdata      = '0;
        bus.flush             = 1'b0;
        bus.wb_allow          = 1'b1;
        test_reset();
        test_alu();
        test_loads();
        test_flush_wait();
        test_flush_dataok();
        test_back_to_back();
        test_rst_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
